exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the 5-stage in-order core. It sits between the decode stage and the memory stage.
- It latches the decoded bundle from decode and evaluates the 12-op ALU.
- It issues the data-SRAM request for ld.w/st.w and passes the result bundle to the memory stage.
- It drives the execute-side forward/stall bus back to decode for RAW hazard resolution.

Parameters:
- none (all bus widths fixed by mycpu.vh: DS_TO_ES_BUS_WD=151, ES_TO_MS_BUS_WD=71, ES_TO_DS_BUS_WD=39)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- ms_allowin  input  1  memory stage can accept
- es_allowin  output  1  this stage can accept
- ds_to_es_valid  input  1  decode bundle valid
- ds_to_es_bus  input  151  MSB→LSB fields:
  - alu_op[11:0]
  - load_op
  - src1_is_pc
  - src2_is_imm
  - src2_is_4
  - gr_we
  - store_op
  - dest[4:0]
  - imm[31:0]
  - rj_value[31:0]
  - rkd_value[31:0]
  - pc[31:0]
- es_to_ms_valid  output  1  bundle to memory stage valid
- es_to_ms_bus  output  71  MSB→LSB fields: res_from_mem, gr_we, dest[4:0], alu_result[31:0], pc[31:0]
- es_to_ds_valid  output  1  equals es_valid
- es_to_ds_forward_bus  output  39  MSB→LSB fields: dep_need_stall, fwd_enable, fwd_reg[4:0], fwd_data[31:0]
- data_sram_en  output  1  data SRAM request
- data_sram_we  output  4  byte write enables
- data_sram_addr  output  32  byte address
- data_sram_wdata  output  32  store data

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk.
- Stage state:
  - es_valid register; reset → 0.
  - Bundle register es_bus_r (151 bits); reset → 0.
- Handshake:
  - es_ready_go = 1 (single-cycle stage).
  - es_allowin = !es_valid || (es_ready_go && ms_allowin).
  - es_to_ms_valid = es_valid && es_ready_go.
  - On each clock, if es_allowin then es_valid <= ds_to_es_valid.
  - es_bus_r is loaded only when ds_to_es_valid && es_allowin; otherwise it holds.
  - A stalled bundle (ms_allowin=0) holds all outputs stable.
- Operand select:
  - src1 = src1_is_pc ? pc : rj_value.
  - src2 = src2_is_imm ? imm : rkd_value.
  - src2_is_4 is informational only; decode has already placed 4 in imm.
- ALU: alu_op is one-hot. Result by bit, all arithmetic mod 2^32:
  - [0] add: src1+src2
  - [1] sub: src1-src2
  - [2] slt: signed compare, result 1 if src1<src2, else 0
  - [3] sltu: unsigned compare, result 1 if src1<src2, else 0
  - [4] and
  - [5] nor
  - [6] or
  - [7] xor
  - [8] sll: src1<<src2[4:0]
  - [9] srl: logical right shift by src2[4:0]
  - [10] sra: arithmetic right shift by src2[4:0]
  - [11] lu12i: result = src2
  - All bits zero → result 0.
  - Results are OR-combined under one-hot masks; no priority encoding.
- Memory request:
  - data_sram_en = es_valid && (load_op || store_op) && ms_allowin.
  - The request is issued exactly once, in the cycle the bundle advances.
  - data_sram_we = (es_valid && store_op && ms_allowin) ? 4'hf : 4'h0.
  - data_sram_addr = alu_result.
  - data_sram_wdata = rkd_value.
- es_to_ms_bus fields:
  - res_from_mem = load_op.
  - gr_we, dest, pc passed through from es_bus_r.
  - alu_result as computed above.
- Forward bus:
  - fwd_hit = es_valid && gr_we && (dest != 0).
  - fwd_enable = fwd_hit.
  - fwd_reg = fwd_hit ? dest : 5'd0.
  - fwd_data = fwd_hit ? alu_result : 32'd0.
  - dep_need_stall = fwd_hit && load_op (load result not yet available).
- Boundary conditions:
  - Bubble (es_valid=0): all SRAM enables 0 and the forward bus is all-zero.
  - Simultaneous drain and fill (es_valid=1, ms_allowin=1, ds_to_es_valid=1): the new bundle is latched with no bubble.
  - reset mid-stall: es_valid clears next edge and the pending request is dropped.
  - dest==0 writes are never forwarded.
  - Shift amounts ≥32 are impossible; only src2[4:0] is used.

Test Plan:
- Reset held 2 cycles → es_valid=0, es_allowin=1, data_sram_en=0, forward bus=39'h0.
- add.w: rj=32'h7FFFFFFF, rkd=1, dest=5 → next cycle:
  - alu_result=32'h80000000
  - fwd_enable=1, fwd_reg=5, dep_need_stall=0
  - es_to_ms_valid=1
- slt vs sltu: src1=32'hFFFFFFFF, src2=1 → slt result=1, sltu result=0.
- sra: src1=32'h80000000, imm=32'h0000001F → 32'hFFFFFFFF.
- srl: same operands → 32'h00000001.
- st.w with rj=32'h1000, imm=8, rkd=32'hDEADBEEF, ms_allowin=0 for 3 cycles then 1:
  - en/we stay 0 while stalled and es_allowin=0.
  - In the release cycle only: en=1, we=4'hf, addr=32'h1008, wdata=32'hDEADBEEF.
- ld.w to r7 → dep_need_stall=1, fwd_reg=7.
- Back-to-back bundle issued the same cycle ld.w drains → no bubble.
- Instruction with gr_we=1, dest=0 → fwd_enable=0, fwd_reg=0.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage of the 5-stage in-order core.
// Holds one decoded bundle, evaluates the one-hot ALU, issues the data-SRAM
// request for loads/stores, and drives the forward/stall bus back to decode.
module exe_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         ms_allowin,
  output logic         es_allowin,
  input  logic         ds_to_es_valid,
  input  logic [150:0] ds_to_es_bus,
  output logic         es_to_ms_valid,
  output logic [70:0]  es_to_ms_bus,
  output logic         es_to_ds_valid,
  output logic [38:0]  es_to_ds_forward_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_we,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata
);

  logic         es_valid_q, es_valid_d;
  logic [150:0] es_bus_q, es_bus_d;

  // single-cycle stage: always ready to hand over once memory accepts
  logic es_ready_go;
  assign es_ready_go = 1'b1;

  // decoded bundle fields
  logic [11:0] alu_op;
  logic        load_op, src1_is_pc, src2_is_imm, src2_is_4, gr_we, store_op;
  logic [4:0]  dest;
  logic [31:0] imm, rj_value, rkd_value, pc;

  assign {alu_op, load_op, src1_is_pc, src2_is_imm, src2_is_4, gr_we, store_op,
          dest, imm, rj_value, rkd_value, pc} = es_bus_q;

  // src2_is_4 only documents decode's choice; imm already carries the 4
  logic unused_src2_is_4;
  assign unused_src2_is_4 = src2_is_4;

  logic [31:0] src1, src2;
  assign src1 = src1_is_pc  ? pc  : rj_value;
  assign src2 = src2_is_imm ? imm : rkd_value;

  // handshake
  assign es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid_q && es_ready_go;
  assign es_to_ds_valid = es_valid_q;

  // next-state for the valid flag and bundle register
  always_comb begin
    es_valid_d = es_valid_q;
    es_bus_d   = es_bus_q;
    if (es_allowin) begin
      es_valid_d = ds_to_es_valid;
    end
    if (ds_to_es_valid && es_allowin) begin
      es_bus_d = ds_to_es_bus;
    end
  end

  // stage registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid_q <= 1'b0;
      es_bus_q   <= '0;
    end else begin
      es_valid_q <= es_valid_d;
      es_bus_q   <= es_bus_d;
    end
  end

  // per-op results; selected below by OR under one-hot masks
  logic [31:0] add_r, sub_r, slt_r, sltu_r, and_r, nor_r, or_r, xor_r;
  logic [31:0] sll_r, srl_r, sra_r, lui_r;
  logic [4:0]  sa;

  assign sa     = src2[4:0];
  assign add_r  = src1 + src2;
  assign sub_r  = src1 - src2;
  assign slt_r  = {31'd0, $signed(src1) < $signed(src2)};
  assign sltu_r = {31'd0, src1 < src2};
  assign and_r  = src1 & src2;
  assign nor_r  = ~(src1 | src2);
  assign or_r   = src1 | src2;
  assign xor_r  = src1 ^ src2;
  assign sll_r  = src1 << sa;
  assign srl_r  = src1 >> sa;
  assign sra_r  = $unsigned($signed(src1) >>> sa);
  assign lui_r  = src2;

  logic [31:0] alu_result;

  // one-hot result mux, no priority between op bits
  always_comb begin
    alu_result = ({32{alu_op[0]}}  & add_r)
               | ({32{alu_op[1]}}  & sub_r)
               | ({32{alu_op[2]}}  & slt_r)
               | ({32{alu_op[3]}}  & sltu_r)
               | ({32{alu_op[4]}}  & and_r)
               | ({32{alu_op[5]}}  & nor_r)
               | ({32{alu_op[6]}}  & or_r)
               | ({32{alu_op[7]}}  & xor_r)
               | ({32{alu_op[8]}}  & sll_r)
               | ({32{alu_op[9]}}  & srl_r)
               | ({32{alu_op[10]}} & sra_r)
               | ({32{alu_op[11]}} & lui_r);
  end

  // memory request fires only in the cycle the bundle advances
  assign data_sram_en    = es_valid_q && (load_op || store_op) && ms_allowin;
  assign data_sram_we    = (es_valid_q && store_op && ms_allowin) ? 4'hf : 4'h0;
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = rkd_value;

  assign es_to_ms_bus = {load_op, gr_we, dest, alu_result, pc};

  // forwarding: r0 writes are never forwarded; loads force decode to wait
  logic fwd_hit;
  assign fwd_hit = es_valid_q && gr_we && (dest != 5'd0);

  assign es_to_ds_forward_bus = {fwd_hit && load_op,
                                 fwd_hit,
                                 fwd_hit ? dest : 5'd0,
                                 fwd_hit ? alu_result : 32'd0};

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed cases plus randomized bundles
// compared against an arithmetic reference model.
module tb_exe_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [150:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic         es_to_ds_valid;
  logic [38:0]  es_to_ds_forward_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk                  (clk),
    .reset                (reset),
    .ms_allowin           (ms_allowin),
    .es_allowin           (es_allowin),
    .ds_to_es_valid       (ds_to_es_valid),
    .ds_to_es_bus         (ds_to_es_bus),
    .es_to_ms_valid       (es_to_ms_valid),
    .es_to_ms_bus         (es_to_ms_bus),
    .es_to_ds_valid       (es_to_ds_valid),
    .es_to_ds_forward_bus (es_to_ds_forward_bus),
    .data_sram_en         (data_sram_en),
    .data_sram_we         (data_sram_we),
    .data_sram_addr       (data_sram_addr),
    .data_sram_wdata      (data_sram_wdata)
  );

  // build a decode bundle; op < 0 means no ALU op selected
  function automatic logic [150:0] mk(input int op, input logic ld, input logic s1pc,
                                      input logic s2imm, input logic gwe, input logic st,
                                      input logic [4:0] dst, input logic [31:0] imm,
                                      input logic [31:0] rj, input logic [31:0] rkd,
                                      input logic [31:0] pc);
    logic [11:0] oh;
    oh = '0;
    if (op >= 0 && op < 12) oh[op] = 1'b1;
    return {oh, ld, s1pc, s2imm, 1'b0, gwe, st, dst, imm, rj, rkd, pc};
  endfunction

  // reference ALU written from the arithmetic definitions
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    logic [31:0] r;
    sh = int'(b % 32);
    case (op)
      0:  r = a + b;
      1:  r = a + (~b + 32'd1);
      2:  r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      3:  r = (a < b) ? 32'd1 : 32'd0;
      4:  r = a & b;
      5:  r = ~(a | b);
      6:  r = a | b;
      7:  r = a ^ b;
      8:  r = a * (32'd1 << sh);
      9:  r = a / (32'd1 << sh);
      10: begin
        r = a / (32'd1 << sh);
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
      11: r = b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // present one bundle for a cycle, then settle with decode idle
  task automatic issue(input logic [150:0] b);
    ds_to_es_bus   = b;
    ds_to_es_valid = 1'b1;
    ms_allowin     = 1'b1;
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; ms_allowin = 1'b0; ds_to_es_valid = 1'b0; ds_to_es_bus = '0;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0; #1;
    n_checks++; if (es_to_ds_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", es_to_ds_valid); else n_pass++;
    n_checks++; if (es_allowin !== 1'b1) $display("FAIL reset_allowin got=%b exp=1", es_allowin); else n_pass++;
    n_checks++; if (data_sram_en !== 1'b0) $display("FAIL reset_en got=%b exp=0", data_sram_en); else n_pass++;
    n_checks++; if (es_to_ds_forward_bus !== 39'h0) $display("FAIL reset_fwd got=%h exp=0", es_to_ds_forward_bus); else n_pass++;
  endtask

  task automatic test_bubble;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus   = {$urandom, $urandom, $urandom, $urandom, $urandom};
    ms_allowin     = 1'b1;
    @(posedge clk); #2;
    n_checks++; if (es_to_ms_valid !== 1'b0) $display("FAIL bubble_valid got=%b exp=0", es_to_ms_valid); else n_pass++;
    n_checks++; if ({data_sram_en, data_sram_we} !== 5'h0) $display("FAIL bubble_sram got=%b/%h exp=0/0", data_sram_en, data_sram_we); else n_pass++;
    n_checks++; if (es_to_ds_forward_bus !== 39'h0) $display("FAIL bubble_fwd got=%h exp=0", es_to_ds_forward_bus); else n_pass++;
  endtask

  task automatic test_alu_directed;
    issue(mk(0, 0, 0, 0, 1, 0, 5'd5, 32'h0, 32'h7FFF_FFFF, 32'h1, 32'h1C00_0000));
    n_checks++; if (es_to_ms_bus[63:32] !== 32'h8000_0000) $display("FAIL add_result got=%h exp=80000000", es_to_ms_bus[63:32]); else n_pass++;
    n_checks++; if (es_to_ds_forward_bus[38:32] !== {1'b0, 1'b1, 5'd5}) $display("FAIL add_fwd got=%b exp=0100101", es_to_ds_forward_bus[38:32]); else n_pass++;
    n_checks++; if (es_to_ds_forward_bus[31:0] !== 32'h8000_0000) $display("FAIL add_fwd_data got=%h exp=80000000", es_to_ds_forward_bus[31:0]); else n_pass++;
    n_checks++; if (es_to_ms_valid !== 1'b1) $display("FAIL add_ms_valid got=%b exp=1", es_to_ms_valid); else n_pass++;

    issue(mk(2, 0, 0, 0, 1, 0, 5'd3, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h1C00_0004));
    n_checks++; if (es_to_ms_bus[63:32] !== 32'd1) $display("FAIL slt got=%h exp=1", es_to_ms_bus[63:32]); else n_pass++;
    issue(mk(3, 0, 0, 0, 1, 0, 5'd3, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h1C00_0008));
    n_checks++; if (es_to_ms_bus[63:32] !== 32'd0) $display("FAIL sltu got=%h exp=0", es_to_ms_bus[63:32]); else n_pass++;
    issue(mk(10, 0, 0, 1, 1, 0, 5'd4, 32'h1F, 32'h8000_0000, 32'h0, 32'h1C00_000C));
    n_checks++; if (es_to_ms_bus[63:32] !== 32'hFFFF_FFFF) $display("FAIL sra got=%h exp=ffffffff", es_to_ms_bus[63:32]); else n_pass++;
    issue(mk(9, 0, 0, 1, 1, 0, 5'd4, 32'h1F, 32'h8000_0000, 32'h0, 32'h1C00_0010));
    n_checks++; if (es_to_ms_bus[63:32] !== 32'h1) $display("FAIL srl got=%h exp=1", es_to_ms_bus[63:32]); else n_pass++;
    issue(mk(-1, 0, 0, 0, 1, 0, 5'd4, 32'h1F, 32'h1234, 32'h55, 32'h1C00_0014));
    n_checks++; if (es_to_ms_bus[63:32] !== 32'h0) $display("FAIL no_op got=%h exp=0", es_to_ms_bus[63:32]); else n_pass++;
  endtask

  task automatic test_store_stall;
    logic [70:0] held;
    ds_to_es_bus   = mk(0, 0, 0, 1, 0, 1, 5'd0, 32'h8, 32'h1000, 32'hDEAD_BEEF, 32'h1C00_0100);
    ds_to_es_valid = 1'b1;
    ms_allowin     = 1'b1;
    @(posedge clk); #1;
    ms_allowin     = 1'b0;
    // a competing bundle must not be taken while stalled
    ds_to_es_bus   = mk(0, 0, 0, 0, 1, 0, 5'd9, 32'h0, 32'h1, 32'h1, 32'h1C00_0104);
    #1;
    held = es_to_ms_bus;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({data_sram_en, data_sram_we} !== 5'h0) $display("FAIL st_stall_sram cyc=%0d got=%b/%h exp=0/0", i, data_sram_en, data_sram_we); else n_pass++;
      n_checks++; if (es_allowin !== 1'b0) $display("FAIL st_stall_allowin cyc=%0d got=%b exp=0", i, es_allowin); else n_pass++;
      n_checks++; if (es_to_ms_bus !== held || held[31:0] !== 32'h1C00_0100) $display("FAIL st_stall_hold cyc=%0d got=%h exp_pc=1c000100", i, es_to_ms_bus); else n_pass++;
      @(posedge clk); #2;
    end
    ds_to_es_valid = 1'b0;
    ms_allowin     = 1'b1;
    #1;
    n_checks++; if ({data_sram_en, data_sram_we} !== 5'b1_1111) $display("FAIL st_release_sram got=%b/%h exp=1/f", data_sram_en, data_sram_we); else n_pass++;
    n_checks++; if (data_sram_addr !== 32'h1008) $display("FAIL st_addr got=%h exp=00001008", data_sram_addr); else n_pass++;
    n_checks++; if (data_sram_wdata !== 32'hDEAD_BEEF) $display("FAIL st_wdata got=%h exp=deadbeef", data_sram_wdata); else n_pass++;
    @(posedge clk); #2;
    n_checks++; if ({data_sram_en, data_sram_we} !== 5'h0) $display("FAIL st_after_sram got=%b/%h exp=0/0", data_sram_en, data_sram_we); else n_pass++;
  endtask

  task automatic test_load_forward;
    issue(mk(0, 1, 0, 1, 1, 0, 5'd7, 32'h10, 32'h2000, 32'h0, 32'h1C00_0200));
    n_checks++; if (es_to_ds_forward_bus !== {1'b1, 1'b1, 5'd7, 32'h2010}) $display("FAIL ld_fwd got=%h exp=%h", es_to_ds_forward_bus, {1'b1, 1'b1, 5'd7, 32'h2010}); else n_pass++;
    n_checks++; if ({data_sram_en, data_sram_we} !== 5'b1_0000) $display("FAIL ld_sram got=%b/%h exp=1/0", data_sram_en, data_sram_we); else n_pass++;
    n_checks++; if (es_to_ms_bus[70] !== 1'b1) $display("FAIL ld_res_from_mem got=%b exp=1", es_to_ms_bus[70]); else n_pass++;
  endtask

  task automatic test_back_to_back;
    ds_to_es_bus   = mk(0, 1, 0, 1, 1, 0, 5'd7, 32'h4, 32'h3000, 32'h0, 32'h1C00_0300);
    ds_to_es_valid = 1'b1;
    ms_allowin     = 1'b1;
    @(posedge clk); #1;
    ds_to_es_bus   = mk(6, 0, 1, 1, 1, 0, 5'd8, 32'h4, 32'h0, 32'h0, 32'h1C00_0304);
    #1;
    n_checks++; if (es_allowin !== 1'b1 || data_sram_en !== 1'b1) $display("FAIL b2b_drain got=%b/%b exp=1/1", es_allowin, data_sram_en); else n_pass++;
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
    #1;
    n_checks++; if (es_to_ds_valid !== 1'b1 || es_to_ms_bus[31:0] !== 32'h1C00_0304) $display("FAIL b2b_fill got=%b/%h exp=1/1c000304", es_to_ds_valid, es_to_ms_bus[31:0]); else n_pass++;
    n_checks++; if (es_to_ms_bus[63:32] !== 32'h1C00_0304) $display("FAIL b2b_pc_or got=%h exp=1c000304", es_to_ms_bus[63:32]); else n_pass++;
  endtask

  task automatic test_dest_zero;
    issue(mk(0, 1, 0, 0, 1, 0, 5'd0, 32'h0, 32'h11, 32'h22, 32'h1C00_0400));
    n_checks++; if (es_to_ds_forward_bus !== 39'h0) $display("FAIL dest0_fwd got=%h exp=0", es_to_ds_forward_bus); else n_pass++;
    n_checks++; if (es_to_ms_bus[69:64] !== 6'b1_00000) $display("FAIL dest0_ms got=%b exp=100000", es_to_ms_bus[69:64]); else n_pass++;
  endtask

  task automatic test_reset_mid_stall;
    ds_to_es_bus   = mk(0, 0, 0, 1, 0, 1, 5'd0, 32'h4, 32'h5000, 32'h1, 32'h1C00_0500);
    ds_to_es_valid = 1'b1;
    ms_allowin     = 1'b1;
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
    ms_allowin     = 1'b0;
    reset          = 1'b1;
    @(posedge clk); #1;
    reset          = 1'b0;
    ms_allowin     = 1'b1;
    #1;
    n_checks++; if (es_to_ds_valid !== 1'b0) $display("FAIL rst_stall_valid got=%b exp=0", es_to_ds_valid); else n_pass++;
    n_checks++; if ({data_sram_en, data_sram_we} !== 5'h0) $display("FAIL rst_stall_sram got=%b/%h exp=0/0", data_sram_en, data_sram_we); else n_pass++;
  endtask

  task automatic test_random;
    for (int it = 0; it < 60; it++) begin
      int          op, kind;
      logic        s1pc, s2imm, gwe, ld, st, hit;
      logic [4:0]  dst;
      logic [31:0] imm, rj, rkd, pc, a, b, res;
      op    = int'($urandom_range(0, 12)) - 1;
      kind  = int'($urandom_range(0, 2));
      ld    = (kind == 1);
      st    = (kind == 2);
      s1pc  = 1'($urandom);
      s2imm = 1'($urandom);
      gwe   = 1'($urandom);
      dst   = 5'($urandom_range(0, 31));
      imm   = $urandom; rj = $urandom; rkd = $urandom; pc = $urandom;
      a     = s1pc ? pc : rj;
      b     = s2imm ? imm : rkd;
      res   = ref_alu(op, a, b);
      hit   = gwe && (dst != 5'd0);
      issue(mk(op, ld, s1pc, s2imm, gwe, st, dst, imm, rj, rkd, pc));
      n_checks++; if (es_to_ms_bus !== {ld, gwe, dst, res, pc}) $display("FAIL rnd_ms it=%0d op=%0d got=%h exp=%h", it, op, es_to_ms_bus, {ld, gwe, dst, res, pc}); else n_pass++;
      n_checks++; if (es_to_ds_forward_bus !== {hit && ld, hit, hit ? dst : 5'd0, hit ? res : 32'd0}) $display("FAIL rnd_fwd it=%0d got=%h", it, es_to_ds_forward_bus); else n_pass++;
      n_checks++; if ({data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata} !== {ld || st, st ? 4'hf : 4'h0, res, rkd}) $display("FAIL rnd_sram it=%0d got=%b/%h/%h/%h", it, data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata); else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; ms_allowin = 1'b0; ds_to_es_valid = 1'b0; ds_to_es_bus = '0;
    test_reset;
    test_bubble;
    test_alu_directed;
    test_store_stall;
    test_load_forward;
    test_back_to_back;
    test_dest_zero;
    test_reset_mid_stall;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
